mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port unified RAM between the instruction-fetch request path and the data load/store path of the single-cycle datapath.
- Grants one requester at a time and drives the RAM address, data and strobes from the granted requester.
- Returns per-requester wait/done and load data.
- Data requests have priority; a watchdog aborts accesses the RAM never acknowledges.

Parameters:
- TIMEOUT, 64: max cycles in a grant state without ram_ready before abort; counter width is clog2(TIMEOUT+1).
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iwait  out  1  1 = instruction access not complete
- iload  out  32  instruction read data, valid when iREN & ~iwait
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN & dWEN together is illegal and is treated as dWEN
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  1 = data access not complete
- dload  out  32  data read value, valid when dREN & ~dwait
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ram_ready  in  1  RAM completes the presented access this cycle
- err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Transitions are registered on the CLK rising edge.
- IDLE:
  - RAM strobes 0, ramaddr/ramstore 0.
  - dREN|dWEN -> GNT_D; else iREN -> GNT_I; else stay.
  - Data wins a simultaneous request.
- GNT_D:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. All combinational from the live inputs.
  - Requesters hold their request stable until their wait drops.
- GNT_I:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion:
  - ram_ready=1 in a grant state completes the access: the granted wait=0 for exactly that cycle, and dload/iload=ramload combinationally.
  - Next state is IDLE, so there is a one-cycle gap between back-to-back grants.
  - Best-case latency: request seen in IDLE at cycle N, grant at N+1, done at N+1 if ram_ready=1.
- Wait signals:
  - iwait=1 whenever iREN=1 and the current cycle is not a completing GNT_I cycle; otherwise 0. dwait is the same for data in GNT_D.
  - wait=0 whenever the corresponding request is low.
- Request drop: the granted request falls before ram_ready -> return to IDLE next cycle, strobes drop immediately (combinational), no err.
- Watchdog:
  - Counter clears on entry to a grant state and increments each grant cycle without ram_ready.
  - When it reaches TIMEOUT: err=1 for one cycle, granted wait=0 that cycle, load data=0, next state IDLE.
- Output muxing: ram_ready in IDLE is ignored; iload/dload are 0 when not completing.
- Reset: RST asserted at any time, including mid-access, forces IDLE immediately.
  - Counters clear; all RAM strobes 0.
  - err=0; iwait=iREN, dwait=dREN|dWEN.
  - No partial write may issue after RST rises.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive GNT_D grants completed while iREN=1.
  - When it reaches STARVE_MAX, the next IDLE decision grants I even if data is pending.
  - The counter clears on any GNT_I grant or when iREN=0.
- Undefined: strict data priority, no counter.

Test Plan:
- Single fetch: iREN=1, iaddr=0x0000_0040, ram_ready=1 on first GNT_I cycle, ramload=0x2001_0005 -> GNT_I at cycle 1; iwait=0 and iload=0x2001_0005 at cycle 1; IDLE at cycle 2.
- Collision: iREN=1 and dWEN=1 (daddr=0x80, dstore=0xDEAD_BEEF) in the same cycle, ram_ready=1 -> GNT_D first with ramWEN=1, ramaddr=0x80, ramstore=0xDEAD_BEEF; IDLE gap; then GNT_I completes; iwait held 1 until then.
- Watchdog: dREN=1, ram_ready=0 forever, TIMEOUT=64 -> err pulses exactly once, 64 cycles after grant entry; dwait=0 and dload=0 that cycle; IDLE after.
- Reset mid-write: RST asserted during GNT_D with dWEN=1 -> ramWEN=0 in the same cycle without waiting for a clock; FSM in IDLE after RST releases.
- Starvation (ARB_STARVE_GUARD_EN, STARVE_MAX=4): dREN and iREN held high, ram_ready=1 -> grant order D,D,D,D,I,D,... ; without macro -> D only, iwait stays 1.
- Request drop: dREN falls after two GNT_D cycles with ram_ready=0 -> ramREN=0 the same cycle, IDLE next cycle, err stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and data load/store.
// Define ARB_STARVE_GUARD_EN to bound consecutive data grants while a fetch is pending.
module mem_arbiter #(
   parameter int TIMEOUT    = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready,
   output logic        err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t        state, nstate, cur;
   logic [CW-1:0] cnt;
   logic          dreq, req, done, abort, i_first;

   assign dreq = dREN | dWEN;
   // Outputs decode from cur so strobes fall with RST itself, independent of the flop clear.
   assign cur  = RST ? IDLE : state;

   always_comb begin
      req = 1'b0;
      case (cur)
         GNT_I:   req = iREN;
         GNT_D:   req = dreq;
         default: req = 1'b0;
      endcase
   end

   assign done  = req & ram_ready;
   assign abort = req & ~ram_ready & (cnt == TO_VAL);

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
   logic [SW-1:0] scnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                               scnt <= '0;
      else if (!iREN || state == GNT_I)      scnt <= '0;
      else if (state == GNT_D && done && scnt != SMAX) scnt <= scnt + 1'b1;
   end

   assign i_first = iREN & (scnt == SMAX);
`else
   logic unused_starve;
   assign unused_starve = (STARVE_MAX == 0);
   assign i_first       = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE: begin
            if (dreq && !i_first) nstate = GNT_D;
            else if (iREN)        nstate = GNT_I;
         end
         GNT_I, GNT_D: begin
            if (!req || ram_ready || abort) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   // Watchdog: zero on grant entry, counts grant cycles that see no ram_ready.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                   cnt <= '0;
      else if (state == IDLE || nstate != state) cnt <= '0;
      else                                       cnt <= cnt + 1'b1;
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = iREN;
      dwait    = dreq;
      iload    = '0;
      dload    = '0;
      err      = abort;
      case (cur)
         GNT_I: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (done || abort) iwait = 1'b0;
            if (done)          iload = ramload;
         end
         GNT_D: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (done || abort) dwait = 1'b0;
            if (done)          dload = ramload;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level ownership model of the arbitration rules.
module tb_mem_arbiter;
   localparam int TIMEOUT    = 64;
   localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN, ram_ready;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic        iwait, dwait, ramREN, ramWEN, err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready), .err(err)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      RST = 1'b1; iREN = 1; dWEN = 1; daddr = 32'h10; ram_ready = 1;
      #1;
      checks++; if (ramREN !== 1'b0)  begin errors++; $display("FAIL reset_ramREN got %b want 0", ramREN); end
      checks++; if (ramWEN !== 1'b0)  begin errors++; $display("FAIL reset_ramWEN got %b want 0", ramWEN); end
      checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (iwait !== 1'b1)   begin errors++; $display("FAIL reset_iwait got %b want 1", iwait); end
      checks++; if (dwait !== 1'b1)   begin errors++; $display("FAIL reset_dwait got %b want 1", dwait); end
      tick();
      checks++; if (ramWEN !== 1'b0)  begin errors++; $display("FAIL reset_held_ramWEN got %b want 0", ramWEN); end
      do_reset();
   endtask

   task automatic test_single_fetch();
      do_reset();
      iREN = 1; iaddr = 32'h0000_0040; ram_ready = 1; ramload = 32'h2001_0005;
      #1;
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_c0_ramREN got %b want 0", ramREN); end
      checks++; if (iwait !== 1'b1)  begin errors++; $display("FAIL fetch_c0_iwait got %b want 1", iwait); end
      tick(); #1;
      checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL fetch_c1_ramREN got %b want 1", ramREN); end
      checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_c1_ramaddr got %h want 40", ramaddr); end
      checks++; if (iwait !== 1'b0)  begin errors++; $display("FAIL fetch_c1_iwait got %b want 0", iwait); end
      checks++; if (iload !== 32'h2001_0005) begin errors++; $display("FAIL fetch_c1_iload got %h want 20010005", iload); end
      tick(); #1;
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_c2_idle_ramREN got %b want 0", ramREN); end
      checks++; if (iload !== 32'h0) begin errors++; $display("FAIL fetch_c2_iload got %h want 0", iload); end
      iREN = 0;
   endtask

   task automatic test_collision();
      do_reset();
      iREN = 1; iaddr = 32'h0000_0300; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
      ram_ready = 1; ramload = 32'h0BAD_F00D;
      tick(); #1;
      checks++; if (ramWEN !== 1'b1) begin errors++; $display("FAIL coll_d_ramWEN got %b want 1", ramWEN); end
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL coll_d_ramREN got %b want 0", ramREN); end
      checks++; if (ramaddr !== 32'h80) begin errors++; $display("FAIL coll_d_ramaddr got %h want 80", ramaddr); end
      checks++; if (ramstore !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_d_ramstore got %h want deadbeef", ramstore); end
      checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL coll_d_dwait got %b want 0", dwait); end
      checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL coll_d_iwait got %b want 1", iwait); end
      tick();
      dWEN = 0; #1;
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL coll_gap_ramREN got %b want 0", ramREN); end
      checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL coll_gap_iwait got %b want 1", iwait); end
      tick(); #1;
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL coll_i_grant got ren=%b addr=%h want ren=1 addr=300", ramREN, ramaddr); end
      checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL coll_i_iwait got %b want 0", iwait); end
      checks++; if (iload !== 32'h0BAD_F00D) begin errors++; $display("FAIL coll_i_iload got %h want 0badf00d", iload); end
      tick();
      iREN = 0;
   endtask

   task automatic test_watchdog();
      int pulses, at;
      do_reset();
      dREN = 1; daddr = 32'h1234; ram_ready = 0; ramload = 32'hFFFF_FFFF;
      pulses = 0; at = -1;
      tick();
      for (int c = 1; c <= 66; c++) begin
         #1;
         if (err === 1'b1) begin pulses++; at = c; end
         checks++; if (err !== (c == 65)) begin errors++; $display("FAIL wd_err c=%0d got %b want %b", c, err, (c == 65)); end
         if (c == 65) begin
            checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL wd_abort_dwait got %b want 0", dwait); end
            checks++; if (dload !== 32'h0) begin errors++; $display("FAIL wd_abort_dload got %h want 0", dload); end
         end
         if (c == 66) begin
            checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL wd_idle_ramREN got %b want 0", ramREN); end
            checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL wd_idle_dwait got %b want 1", dwait); end
         end
         tick();
      end
      checks++; if (pulses != 1 || at != 65) begin errors++; $display("FAIL wd_pulse got count=%0d at=%0d want count=1 at=65", pulses, at); end
      dREN = 0;
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      dWEN = 1; daddr = 32'h44; dstore = 32'h1234_5678; ram_ready = 0;
      tick(); #1;
      checks++; if (ramWEN !== 1'b1) begin errors++; $display("FAIL rstw_pre_ramWEN got %b want 1", ramWEN); end
      RST = 1'b1; #1;
      checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rstw_async_ramWEN got %b want 0", ramWEN); end
      checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rstw_async_ramaddr got %h want 0", ramaddr); end
      checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rstw_async_dwait got %b want 1", dwait); end
      tick(); tick();
      RST = 1'b0; #1;
      checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rstw_release_ramWEN got %b want 0", ramWEN); end
      tick(); #1;
      checks++; if (ramWEN !== 1'b1) begin errors++; $display("FAIL rstw_regrant_ramWEN got %b want 1", ramWEN); end
      dWEN = 0;
   endtask

   task automatic test_request_drop();
      do_reset();
      dREN = 1; daddr = 32'h500; ram_ready = 0;
      tick(); #1;
      checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL drop_g1_ramREN got %b want 1", ramREN); end
      tick(); #1;
      checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL drop_g2_ramREN got %b want 1", ramREN); end
      tick();
      dREN = 0; #1;
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_now_ramREN got %b want 0", ramREN); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_now_err got %b want 0", err); end
      tick();
      iREN = 1; iaddr = 32'h600; ram_ready = 1; ramload = 32'hCAFE_0001; #1;
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_idle_ramREN got %b want 0", ramREN); end
      tick(); #1;
      checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin errors++; $display("FAIL drop_next_grant got ren=%b addr=%h want ren=1 addr=600", ramREN, ramaddr); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_err got %b want 0", err); end
      tick();
      iREN = 0; ram_ready = 0;
   endtask

   task automatic test_starvation();
      logic        odd, exp_i;
      logic [31:0] exp_addr;
      do_reset();
      iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; ram_ready = 1; ramload = 32'h7777_0000;
      for (int c = 0; c < 40; c++) begin
         #1;
         odd      = (c % 2 == 1);
         exp_i    = odd && STARVE_ON && (((c - 1) / 2) % 5 == 4);
         exp_addr = !odd ? 32'h0 : (exp_i ? 32'h100 : 32'h200);
         checks++; if (ramREN !== odd) begin errors++; $display("FAIL starve_ramREN c=%0d got %b want %b", c, ramREN, odd); end
         checks++; if (ramaddr !== exp_addr) begin errors++; $display("FAIL starve_order c=%0d got %h want %h", c, ramaddr, exp_addr); end
         checks++; if (iwait !== !exp_i) begin errors++; $display("FAIL starve_iwait c=%0d got %b want %b", c, iwait, !exp_i); end
         tick();
      end
      iREN = 0; dREN = 0; ram_ready = 0;
   endtask

   // Randomized traffic against an ownership model: who holds the RAM and for how long.
   task automatic test_random(input int ncyc);
      int          own, waited, sc, stall, k;
      logic        dreq, greq, p_iw, p_dw;
      logic        e_ren, e_wen, e_iw, e_dw, e_err;
      logic [31:0] e_addr, e_store, e_il, e_dl;
      do_reset();
      own = 0; waited = 0; sc = 0; stall = 0; p_iw = 1; p_dw = 1;
      for (int c = 0; c < ncyc; c++) begin
         if (iREN && (!p_iw || $urandom_range(0, 99) == 0)) iREN = 0;
         else if (!iREN && $urandom_range(0, 2) == 0) begin iREN = 1; iaddr = $urandom; end
         if ((dREN || dWEN) && (!p_dw || $urandom_range(0, 99) == 0)) begin dREN = 0; dWEN = 0; end
         else if (!(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 4);
            dREN = (k < 2) || (k == 4);
            dWEN = (k >= 2);
            daddr = $urandom; dstore = $urandom;
         end
         if (stall > 0) begin ram_ready = 0; stall--; end
         else begin
            if ($urandom_range(0, 149) == 0) stall = 70;
            ram_ready = ($urandom_range(0, 2) != 0);
         end
         ramload = $urandom;
         #1;
         dreq = dREN | dWEN;
         e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0; e_err = 0;
         e_iw = iREN; e_dw = dreq;
         if (own == 1) begin
            e_ren = iREN; e_addr = iaddr;
            if (iREN && ram_ready) begin e_iw = 0; e_il = ramload; end
            else if (iREN && waited == TIMEOUT) begin e_iw = 0; e_err = 1; end
         end else if (own == 2) begin
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
            if (dreq && ram_ready) begin e_dw = 0; e_dl = ramload; end
            else if (dreq && waited == TIMEOUT) begin e_dw = 0; e_err = 1; end
         end
         checks++; if (ramREN !== e_ren) begin errors++; $display("FAIL rnd_ramREN c=%0d got %b want %b", c, ramREN, e_ren); end
         checks++; if (ramWEN !== e_wen) begin errors++; $display("FAIL rnd_ramWEN c=%0d got %b want %b", c, ramWEN, e_wen); end
         checks++; if (ramaddr !== e_addr) begin errors++; $display("FAIL rnd_ramaddr c=%0d got %h want %h", c, ramaddr, e_addr); end
         checks++; if (ramstore !== e_store) begin errors++; $display("FAIL rnd_ramstore c=%0d got %h want %h", c, ramstore, e_store); end
         checks++; if (iwait !== e_iw) begin errors++; $display("FAIL rnd_iwait c=%0d got %b want %b", c, iwait, e_iw); end
         checks++; if (dwait !== e_dw) begin errors++; $display("FAIL rnd_dwait c=%0d got %b want %b", c, dwait, e_dw); end
         checks++; if (iload !== e_il) begin errors++; $display("FAIL rnd_iload c=%0d got %h want %h", c, iload, e_il); end
         checks++; if (dload !== e_dl) begin errors++; $display("FAIL rnd_dload c=%0d got %h want %h", c, dload, e_dl); end
         checks++; if (err !== e_err) begin errors++; $display("FAIL rnd_err c=%0d got %b want %b", c, err, e_err); end
         if (!iREN || own == 1) sc = 0;
         else if (own == 2 && dreq && ram_ready && sc < STARVE_MAX) sc++;
         if (own == 0) begin
            waited = 0;
            if (dreq && !(STARVE_ON && iREN && sc >= STARVE_MAX)) own = 2;
            else if (iREN) own = 1;
         end else begin
            greq = (own == 1) ? iREN : dreq;
            if (!greq || ram_ready || waited == TIMEOUT) begin own = 0; waited = 0; end
            else waited++;
         end
         p_iw = e_iw; p_dw = e_dw;
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      test_reset();
      test_single_fetch();
      test_collision();
      test_watchdog();
      test_reset_mid_write();
      test_request_drop();
      test_starvation();
      test_random(3000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
